// File: rtl/interrupt_dispatcher.sv
// interrupt_dispatcher: IF/IME bookkeeping, priority select and 5 M-cycle interrupt dispatch sequencer
module interrupt_dispatcher #(
  parameter int          NUM_IRQ   = 5,
  parameter logic [15:0] VEC_BASE  = 16'h40,
  parameter int          VEC_SHIFT = 3
) (
  input  logic               i_Clk,
  input  logic               i_Reset_n,
  input  logic               i_M_Tick,
  input  logic [NUM_IRQ-1:0] i_Irq_Req,
  input  logic [NUM_IRQ-1:0] i_IE,
  input  logic               i_IF_Wr,
  input  logic [NUM_IRQ-1:0] i_IF_Wdata,
  input  logic               i_Instr_Bound,
  input  logic               i_Ei,
  input  logic               i_Di,
  input  logic               i_Reti,
  output logic [NUM_IRQ-1:0] o_IF,
  output logic               o_Ime,
  output logic               o_Wake,
  output logic               o_Busy,
  output logic               o_Push_Hi,
  output logic               o_Push_Lo,
  output logic               o_Vec_Valid,
  output logic [15:0]        o_Vector
);
  localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
  typedef enum logic [2:0] {IDLE, WAIT1, WAIT2, PUSH_HI, PUSH_LO, JUMP} state_t;
  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] if_q, if_d, pend, clr;
  logic               ime_q, ime_d, ei_q, ei_d, cancel_q, cancel_d;
  logic [IW-1:0]      idx_q, idx_d, sel;
  logic [15:0]        vec_q, vec_d;
  logic               idle, start, latch;
  assign pend = i_IE & if_q;
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) sel = pend[i] ? IW'(i) : sel;
  end
  always_comb begin
    idle     = state_q == IDLE;
    start    = i_M_Tick & idle & i_Instr_Bound & ime_q & |pend;
    latch    = i_M_Tick & (state_q == PUSH_HI);
    clr      = latch & |pend ? NUM_IRQ'(1) << sel : '0;
    if_d     = ((i_IF_Wr ? i_IF_Wdata : if_q) & ~clr) | i_Irq_Req;
    ime_d    = start ? 1'b0 : !(i_M_Tick & idle) ? ime_q : i_Di ? 1'b0 :
               (i_Reti | (ei_q & i_Instr_Bound)) ? 1'b1 : ime_q;
    ei_d     = start ? 1'b0 : !(i_M_Tick & idle) ? ei_q : i_Di ? 1'b0 : i_Ei ? 1'b1 :
               (ei_q & i_Instr_Bound) ? 1'b0 : ei_q;
    state_d  = !i_M_Tick ? state_q : idle ? (start ? WAIT1 : IDLE) :
               state_q == JUMP ? IDLE : state_t'(state_q + 3'd1);
    idx_d    = latch ? sel : idx_q;
    cancel_d = latch ? ~|pend : cancel_q;
    vec_d    = i_M_Tick & (state_q == PUSH_LO) ?
               (cancel_q ? 16'h0000 : VEC_BASE + (16'(idx_q) << VEC_SHIFT)) : vec_q;
  end
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= IDLE;
      if_q     <= '0;
      ime_q    <= 1'b0;
      ei_q     <= 1'b0;
      cancel_q <= 1'b0;
      idx_q    <= '0;
      vec_q    <= '0;
    end else begin
      state_q  <= state_d;
      if_q     <= if_d;
      ime_q    <= ime_d;
      ei_q     <= ei_d;
      cancel_q <= cancel_d;
      idx_q    <= idx_d;
      vec_q    <= vec_d;
    end
  end
  assign o_IF        = if_q;
  assign o_Ime       = ime_q;
  assign o_Wake      = |pend;
  assign o_Busy      = state_q != IDLE;
  assign o_Push_Hi   = state_q == PUSH_HI;
  assign o_Push_Lo   = state_q == PUSH_LO;
  assign o_Vec_Valid = state_q == JUMP;
  assign o_Vector    = vec_q;
endmodule

// File: tb/tb_interrupt_dispatcher.sv
// tb_interrupt_dispatcher: directed self-checking bench for interrupt_dispatcher
module tb_interrupt_dispatcher;
  logic        i_Clk = 1'b0;
  logic        i_Reset_n = 1'b0;
  logic        i_M_Tick = 1'b1;
  logic [4:0]  i_Irq_Req = '0;
  logic [4:0]  i_IE = '0;
  logic        i_IF_Wr = 1'b0;
  logic [4:0]  i_IF_Wdata = '0;
  logic        i_Instr_Bound = 1'b0;
  logic        i_Ei = 1'b0;
  logic        i_Di = 1'b0;
  logic        i_Reti = 1'b0;
  logic [4:0]  o_IF;
  logic        o_Ime, o_Wake, o_Busy, o_Push_Hi, o_Push_Lo, o_Vec_Valid;
  logic [15:0] o_Vector;
  int n_checks = 0;
  int n_fail = 0;
  interrupt_dispatcher dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_M_Tick(i_M_Tick), .i_Irq_Req(i_Irq_Req),
    .i_IE(i_IE), .i_IF_Wr(i_IF_Wr), .i_IF_Wdata(i_IF_Wdata), .i_Instr_Bound(i_Instr_Bound),
    .i_Ei(i_Ei), .i_Di(i_Di), .i_Reti(i_Reti), .o_IF(o_IF), .o_Ime(o_Ime), .o_Wake(o_Wake),
    .o_Busy(o_Busy), .o_Push_Hi(o_Push_Hi), .o_Push_Lo(o_Push_Lo), .o_Vec_Valid(o_Vec_Valid),
    .o_Vector(o_Vector)
  );
  always #5 i_Clk = ~i_Clk;
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge i_Clk);
      #1;
    end
  endtask
  task automatic write_if(input logic [4:0] v);
    i_IF_Wr = 1'b1;
    i_IF_Wdata = v;
    cyc();
    i_IF_Wr = 1'b0;
  endtask
  task automatic reti();
    i_Reti = 1'b1;
    cyc();
    i_Reti = 1'b0;
  endtask
  task automatic bound();
    i_Instr_Bound = 1'b1;
    cyc();
    i_Instr_Bound = 1'b0;
  endtask
  task automatic test_reset();
    cyc(2);
    n_checks++; if (o_IF !== 5'b0) begin n_fail++; $display("FAIL rst_if got %b exp %b", o_IF, 5'b0); end
    n_checks++; if ({o_Ime, o_Wake, o_Busy, o_Push_Hi, o_Push_Lo, o_Vec_Valid} !== 6'b0) begin n_fail++; $display("FAIL rst_flags got %b exp %b", {o_Ime, o_Wake, o_Busy, o_Push_Hi, o_Push_Lo, o_Vec_Valid}, 6'b0); end
    n_checks++; if (o_Vector !== 16'h0000) begin n_fail++; $display("FAIL rst_vec got %h exp %h", o_Vector, 16'h0000); end
    i_Reset_n = 1'b1;
    cyc();
  endtask
  task automatic test_dispatch();
    i_IE = 5'h1F;
    reti();
    n_checks++; if (o_Ime !== 1'b1) begin n_fail++; $display("FAIL t2_ime_set got %b exp 1", o_Ime); end
    i_Irq_Req = 5'b00100;
    cyc();
    i_Irq_Req = '0;
    n_checks++; if (o_IF !== 5'b00100) begin n_fail++; $display("FAIL t2_if_req got %b exp %b", o_IF, 5'b00100); end
    bound();
    n_checks++; if ({o_Busy, o_Ime, o_Push_Hi} !== 3'b100) begin n_fail++; $display("FAIL t2_wait1 got %b exp %b", {o_Busy, o_Ime, o_Push_Hi}, 3'b100); end
    cyc();
    n_checks++; if ({o_Busy, o_Push_Hi, o_Push_Lo, o_Vec_Valid} !== 4'b1000) begin n_fail++; $display("FAIL t2_wait2 got %b exp %b", {o_Busy, o_Push_Hi, o_Push_Lo, o_Vec_Valid}, 4'b1000); end
    cyc();
    n_checks++; if ({o_Push_Hi, o_Push_Lo, o_IF} !== {2'b10, 5'b00100}) begin n_fail++; $display("FAIL t2_push_hi got %b exp %b", {o_Push_Hi, o_Push_Lo, o_IF}, {2'b10, 5'b00100}); end
    cyc();
    n_checks++; if ({o_Push_Hi, o_Push_Lo, o_Vec_Valid, o_IF} !== {3'b010, 5'b0}) begin n_fail++; $display("FAIL t2_push_lo got %b exp %b", {o_Push_Hi, o_Push_Lo, o_Vec_Valid, o_IF}, {3'b010, 5'b0}); end
    cyc();
    n_checks++; if ({o_Vec_Valid, o_Busy, o_Vector} !== {2'b11, 16'h0050}) begin n_fail++; $display("FAIL t2_jump got %b/%h exp 11/0050", {o_Vec_Valid, o_Busy}, o_Vector); end
    cyc();
    n_checks++; if ({o_Vec_Valid, o_Busy, o_Ime, o_Vector} !== {3'b000, 16'h0050}) begin n_fail++; $display("FAIL t2_after got %b/%h exp 000/0050", {o_Vec_Valid, o_Busy, o_Ime}, o_Vector); end
  endtask
  task automatic test_priority();
    write_if(5'b10100);
    reti();
    bound();
    cyc(3);
    n_checks++; if (o_IF !== 5'b10000) begin n_fail++; $display("FAIL t3_if_left got %b exp %b", o_IF, 5'b10000); end
    cyc();
    n_checks++; if ({o_Vec_Valid, o_Vector} !== {1'b1, 16'h0050}) begin n_fail++; $display("FAIL t3_vec1 got %b/%h exp 1/0050", o_Vec_Valid, o_Vector); end
    cyc();
    reti();
    bound();
    cyc(4);
    n_checks++; if ({o_Vec_Valid, o_Vector, o_IF} !== {1'b1, 16'h0060, 5'b0}) begin n_fail++; $display("FAIL t3_vec2 got %b/%h/%b exp 1/0060/00000", o_Vec_Valid, o_Vector, o_IF); end
    cyc();
  endtask
  task automatic test_ei();
    write_if(5'b00010);
    i_Ei = 1'b1;
    cyc();
    i_Ei = 1'b0;
    n_checks++; if (o_Ime !== 1'b0) begin n_fail++; $display("FAIL t4_ei_delay got %b exp 0", o_Ime); end
    bound();
    n_checks++; if ({o_Busy, o_Ime} !== 2'b01) begin n_fail++; $display("FAIL t4_first_bound got %b exp %b", {o_Busy, o_Ime}, 2'b01); end
    bound();
    n_checks++; if ({o_Busy, o_Ime} !== 2'b10) begin n_fail++; $display("FAIL t4_second_bound got %b exp %b", {o_Busy, o_Ime}, 2'b10); end
    cyc(4);
    n_checks++; if ({o_Vec_Valid, o_Vector} !== {1'b1, 16'h0048}) begin n_fail++; $display("FAIL t4_vec got %b/%h exp 1/0048", o_Vec_Valid, o_Vector); end
    cyc();
    write_if(5'b00010);
    i_Ei = 1'b1;
    cyc();
    i_Ei = 1'b0;
    i_Di = 1'b1;
    cyc();
    i_Di = 1'b0;
    bound();
    bound();
    n_checks++; if ({o_Busy, o_Ime} !== 2'b00) begin n_fail++; $display("FAIL t4_ei_di got %b exp %b", {o_Busy, o_Ime}, 2'b00); end
    write_if(5'b0);
  endtask
  task automatic test_cancel();
    write_if(5'b01000);
    reti();
    bound();
    cyc();
    i_IE = 5'b0;
    cyc(2);
    n_checks++; if ({o_Push_Lo, o_IF} !== {1'b1, 5'b01000}) begin n_fail++; $display("FAIL t5_no_clear got %b exp %b", {o_Push_Lo, o_IF}, {1'b1, 5'b01000}); end
    cyc();
    n_checks++; if ({o_Vec_Valid, o_Vector, o_Wake} !== {1'b1, 16'h0000, 1'b0}) begin n_fail++; $display("FAIL t5_cancel_vec got %b/%h/%b exp 1/0000/0", o_Vec_Valid, o_Vector, o_Wake); end
    cyc();
    i_IE = 5'h1F;
    write_if(5'b0);
  endtask
  task automatic test_tick_gate();
    write_if(5'b00001);
    reti();
    bound();
    i_M_Tick = 1'b0;
    cyc(3);
    n_checks++; if ({o_Busy, o_Push_Hi, o_IF} !== {2'b10, 5'b00001}) begin n_fail++; $display("FAIL tg_hold got %b exp %b", {o_Busy, o_Push_Hi, o_IF}, {2'b10, 5'b00001}); end
    i_M_Tick = 1'b1;
    cyc(2);
    n_checks++; if (o_Push_Hi !== 1'b1) begin n_fail++; $display("FAIL tg_resume got %b exp 1", o_Push_Hi); end
    cyc(2);
    n_checks++; if ({o_Vec_Valid, o_Vector} !== {1'b1, 16'h0040}) begin n_fail++; $display("FAIL tg_vec got %b/%h exp 1/0040", o_Vec_Valid, o_Vector); end
    cyc();
  endtask
  task automatic test_wake();
    i_IE = 5'b10000;
    i_Irq_Req = 5'b10000;
    cyc();
    i_Irq_Req = '0;
    n_checks++; if ({o_Wake, o_Busy, o_Ime} !== 3'b100) begin n_fail++; $display("FAIL t6_wake got %b exp %b", {o_Wake, o_Busy, o_Ime}, 3'b100); end
    bound();
    n_checks++; if (o_Busy !== 1'b0) begin n_fail++; $display("FAIL t6_no_busy got %b exp 0", o_Busy); end
    write_if(5'b0);
    n_checks++; if ({o_IF, o_Wake} !== 6'b0) begin n_fail++; $display("FAIL t6_if_clr got %b exp %b", {o_IF, o_Wake}, 6'b0); end
    i_Irq_Req = 5'b10000;
    write_if(5'b0);
    i_Irq_Req = '0;
    n_checks++; if (o_IF !== 5'b10000) begin n_fail++; $display("FAIL t6_req_beats_wr got %b exp %b", o_IF, 5'b10000); end
    i_IE = 5'h1F;
    write_if(5'b0);
  endtask
  task automatic test_reset_mid();
    write_if(5'b00101);
    reti();
    bound();
    cyc(3);
    n_checks++; if ({o_Push_Lo, o_IF} !== {1'b1, 5'b00100}) begin n_fail++; $display("FAIL t1_pre got %b exp %b", {o_Push_Lo, o_IF}, {1'b1, 5'b00100}); end
    i_Reset_n = 1'b0;
    #1;
    n_checks++; if ({o_IF, o_Ime, o_Busy, o_Push_Lo, o_Vec_Valid, o_Wake} !== 10'b0 || o_Vector !== 16'h0) begin n_fail++; $display("FAIL t1_async got %b/%h exp 0/0000", {o_IF, o_Ime, o_Busy, o_Push_Lo, o_Vec_Valid, o_Wake}, o_Vector); end
    cyc();
    i_Reset_n = 1'b1;
    cyc();
    n_checks++; if ({o_Busy, o_Push_Lo, o_IF} !== 7'b0) begin n_fail++; $display("FAIL t1_idle got %b exp %b", {o_Busy, o_Push_Lo, o_IF}, 7'b0); end
  endtask
  initial begin
    test_reset();
    test_dispatch();
    test_priority();
    test_ei();
    test_cancel();
    test_tick_gate();
    test_wake();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
